i2s_word_assembler: RTL and testbench
=====================================

Name: i2s_word_assembler

Overview:
- Sits directly downstream of the I2S ADC deserializer in the bclk domain.
- Consumes its byte-slice stream, which has no backpressure, and packs the slices of each TDM word into one 32-bit left-justified sample.
- Tags each sample with its channel index and end-of-frame.
- Buffers samples in a small FIFO so a backpressuring consumer (CDC FIFO / packetizer) can be attached; also counts frames and flags overflow and framing errors.

Parameters:
- FIFO_DEPTH, 4, output FIFO entries; power of two, >=2.
- CH_WIDTH, 4, width of channel index in m_axis_tuser.

Ports:
- bclk  in  1  sole clock.
- rst  in  1  reset.
- s_axis_tvalid  in  1  byte slice valid; no tready, never stalled.
- s_axis_tdata  in  8  slice, MSB-first; partial final slice valid in upper bits.
- s_axis_tlast  in  1  last slice of frame.
- m_axis_tvalid  out  1  sample valid.
- m_axis_tready  in  1  consumer ready.
- m_axis_tdata  out  32  sample, left-justified, unused LSBs zero.
- m_axis_tuser  out  CH_WIDTH  TDM channel index of sample.
- m_axis_tlast  out  1  last channel of frame.
- i_word_width  in  6  bits per word, 1..32; stable while i_enable=1.
- i_tdm_num  in  5  channels per frame, 1..16; stable while i_enable=1.
- i_enable  in  1  0: discard input, hold counters at start.
- i_clear  in  1  one-cycle pulse; clears o_frame_num and sticky flags.
- o_frame_num  out  32  completed frames.
- o_overflow  out  1  sticky: sample dropped, FIFO full.
- o_frame_err  out  1  sticky: short word or channel-count mismatch at tlast.

Behaviour:
- Clocking/reset: one clock, bclk; reset rst is synchronous, active-high.
- Reset values: FIFO empty, m_axis_tvalid=0, m_axis_tdata/tuser/tlast=0, o_frame_num=0, o_overflow=0, o_frame_err=0, byte_cnt=0, chan_cnt=0, accumulator=0.
- Slices per word: NB = ceil(i_word_width/8), computed as (i_word_width+7)>>3, range 1..4.
- Partial final slice: r = i_word_width mod 8; when r!=0, the final slice keeps bits [7:8-r] and the lower bits are masked to 0 before packing.
- Packing: on each accepted slice (s_axis_tvalid & i_enable), accumulator byte lane [31-8*byte_cnt -: 8] <= masked slice; byte_cnt++.
- Word complete: when byte_cnt==NB-1 or s_axis_tlast, push {acc_next, chan_cnt, tlast_flag} into the FIFO.
  - Push occurs the same cycle; the word appears on m_axis one cycle later when the FIFO was empty (latency 1 from final slice).
  - Then clear accumulator and byte_cnt.
  - chan_cnt <= (tlast) ? 0 : chan_cnt+1; chan_cnt wraps to 0 after i_tdm_num-1 even without tlast.
- tlast_flag = s_axis_tlast | (chan_cnt==i_tdm_num-1).
- Frame count: on s_axis_tlast, o_frame_num increments, wrapping at 2^32.
- o_frame_err set when s_axis_tlast arrives with byte_cnt!=NB-1 (short word, still pushed) or chan_cnt!=i_tdm_num-1.
- FIFO: standard valid/ready; pop on m_axis_tvalid & m_axis_tready. Push and pop in the same cycle while full is allowed (no drop). Push while full without pop: word dropped, o_overflow set, counters still advance.
- Output stability: m_axis_tdata/tuser/tlast stable while tvalid & !tready.
- i_enable=0: input ignored; byte_cnt, chan_cnt and accumulator held at 0; FIFO continues draining.
- i_clear: clears o_frame_num, o_overflow and o_frame_err. If the same cycle has an event, the event takes priority (flag set, counter = 1).
- Reset mid-word: partial word discarded, FIFO flushed.

Optional Feature:
- Macro I2S_ASM_SIGN_EXT_EN.
  - Defined: m_axis_tdata is right-justified and sign-extended (sample >>> (32-i_word_width), arithmetic).
  - Undefined: left-justified, LSBs zero.
- Latency unchanged either way; the shift is combinational at the FIFO write side.

Decomposition:
- Shared package i2s_pkg: constant I2S_MAX_WORD=32, I2S_MAX_TDM=16, function slices_per_word(width).
- One natural sub-module: axis_sync_fifo (DEPTH, WIDTH=32+CH_WIDTH+1; full, empty, push, pop).
- Packing/counter logic stays in the top.

Test Plan:
- Width 24, tdm 2, 3 slices/word, slices A1 B2 C3 / D4 E5 F6 with tlast on F6, tready=1 -> tdata 0xA1B2C300 tuser 0 tlast 0, then 0xD4E5F600 tuser 1 tlast 1; o_frame_num=1.
- Width 20, tdm 1, slices 12 34 5F+tlast -> tdata 0x12345000 (low nibble masked); with I2S_ASM_SIGN_EXT_EN, 0x82345F (MSB 1) -> 0xFFF82345.
- Width 16, tdm 8, tready=0 for 6 words, FIFO_DEPTH=4 -> 4 words held in order, o_overflow=1, channels 0..3 delivered after tready=1.
- tlast after 1 slice of a 16-bit word -> word pushed with low byte 0, o_frame_err=1; i_clear -> flag 0, o_frame_num 0.
- Full FIFO with simultaneous push and pop -> no drop, o_overflow stays 0.
- Reset asserted mid-word then 2 clean frames -> only clean frames output, channel indices start at 0.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared constants and helpers for the I2S word assembler.
package i2s_pkg;

    localparam int unsigned I2S_MAX_WORD = 32;
    localparam int unsigned I2S_MAX_TDM  = 16;
    // Internal channel counter width, enough for I2S_MAX_TDM channels.
    localparam int unsigned I2S_CHAN_CNT_W = $clog2(I2S_MAX_TDM);

    // Number of byte slices carrying one word: ceil(width / 8), 1..4.
    function automatic logic [2:0] slices_per_word(input logic [5:0] width);
        logic [6:0] sum;
        sum = {1'b0, width} + 7'd7;
        return sum[5:3];
    endfunction

    // Keep-mask for a slice; only the final slice of a word with a partial
    // remainder has its unused low bits cleared.
    function automatic logic [7:0] slice_mask(input logic [2:0] rem, input logic final_slice);
        logic [7:0] mask;
        mask = 8'hFF;
        if (final_slice && (rem != 3'd0)) begin
            mask = 8'hFF << (4'd8 - {1'b0, rem});
        end
        return mask;
    endfunction

endpackage

// File: rtl/axis_sync_fifo.sv
// Single-clock valid/ready FIFO. Push while full is accepted only when a
// pop happens in the same cycle; the caller detects drops.
module axis_sync_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 37
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push;
    logic             do_pop;

    // Pointer, occupancy and storage next-state.
    always_comb begin
        empty_o  = (count_q == '0);
        full_o   = (count_q == (AW+1)'(DEPTH));
        do_pop   = pop_i & ~empty_o;
        do_push  = push_i & (~full_o | do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata_i;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
        // Head is forced to zero when empty so outputs are clean at reset.
        rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];
    end

    // State registers; storage itself needs no reset.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/i2s_word_assembler.sv
// Packs MSB-first byte slices from the I2S deserializer into 32-bit TDM
// samples tagged with channel index and end-of-frame, buffered in a FIFO.
// Optional build macro I2S_ASM_SIGN_EXT_EN: right-justify and sign-extend
// samples instead of the default left-justified, zero-padded format.
module i2s_word_assembler
    import i2s_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CH_WIDTH   = 4
) (
    input  logic                bclk,
    input  logic                rst,
    input  logic                s_axis_tvalid,
    input  logic [7:0]          s_axis_tdata,
    input  logic                s_axis_tlast,
    output logic                m_axis_tvalid,
    input  logic                m_axis_tready,
    output logic [31:0]         m_axis_tdata,
    output logic [CH_WIDTH-1:0] m_axis_tuser,
    output logic                m_axis_tlast,
    input  logic [5:0]          i_word_width,
    input  logic [4:0]          i_tdm_num,
    input  logic                i_enable,
    input  logic                i_clear,
    output logic [31:0]         o_frame_num,
    output logic                o_overflow,
    output logic                o_frame_err
);

    localparam int unsigned EntryW = 32 + CH_WIDTH + 1;

    logic [31:0]               acc_q, acc_d;
    logic [1:0]                byte_cnt_q, byte_cnt_d;
    logic [I2S_CHAN_CNT_W-1:0] chan_cnt_q, chan_cnt_d;
    logic [31:0]               frame_num_q, frame_num_d;
    logic                      overflow_q, overflow_d;
    logic                      frame_err_q, frame_err_d;

    logic [2:0]        nb;
    logic              accept;
    logic              last_slice;
    logic              last_chan;
    logic [7:0]        masked;
    logic [31:0]       acc_next;
    logic              word_done;
    logic              tlast_flag;
    logic [31:0]       sample;
    logic [5:0]        shamt;
    logic [EntryW-1:0] fifo_wdata;
    logic [EntryW-1:0] fifo_rdata;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;
    logic              ev_frame;
    logic              ev_err;
    logic              ev_ovf;

    // Slice decode, packing and event detection.
    always_comb begin
        nb         = slices_per_word(i_word_width);
        accept     = s_axis_tvalid & i_enable;
        last_slice = ({1'b0, byte_cnt_q} == (nb - 3'd1));
        last_chan  = ({1'b0, chan_cnt_q} == (i_tdm_num - 5'd1));
        masked     = s_axis_tdata & slice_mask(i_word_width[2:0], last_slice);
        // Accumulator is zero at word start, so OR-ing the shifted lane works.
        acc_next   = acc_q | ({masked, 24'h0} >> {byte_cnt_q, 3'b000});
        word_done  = accept & (last_slice | s_axis_tlast);
        tlast_flag = s_axis_tlast | last_chan;
        shamt      = 6'd32 - i_word_width;
`ifdef I2S_ASM_SIGN_EXT_EN
        sample     = 32'($signed(acc_next) >>> shamt);
`else
        sample     = acc_next;
`endif
        fifo_wdata = {sample, CH_WIDTH'(chan_cnt_q), tlast_flag};
        fifo_pop   = m_axis_tvalid & m_axis_tready;
        ev_frame   = accept & s_axis_tlast;
        ev_err     = ev_frame & (~last_slice | ~last_chan);
        ev_ovf     = word_done & fifo_full & ~fifo_pop;
    end

    // Next-state for packing state, frame counter and sticky flags.
    always_comb begin
        acc_d       = acc_q;
        byte_cnt_d  = byte_cnt_q;
        chan_cnt_d  = chan_cnt_q;
        frame_num_d = i_clear ? 32'd0 : frame_num_q;
        overflow_d  = i_clear ? 1'b0 : overflow_q;
        frame_err_d = i_clear ? 1'b0 : frame_err_q;
        if (!i_enable) begin
            acc_d      = '0;
            byte_cnt_d = '0;
            chan_cnt_d = '0;
        end else if (word_done) begin
            acc_d      = '0;
            byte_cnt_d = '0;
            chan_cnt_d = tlast_flag ? '0 : chan_cnt_q + I2S_CHAN_CNT_W'(1);
        end else if (accept) begin
            acc_d      = acc_next;
            byte_cnt_d = byte_cnt_q + 2'd1;
        end
        // Events win over a same-cycle clear.
        if (ev_frame) begin
            frame_num_d = frame_num_d + 32'd1;
        end
        if (ev_err) begin
            frame_err_d = 1'b1;
        end
        if (ev_ovf) begin
            overflow_d = 1'b1;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge bclk) begin
        if (rst) begin
            acc_q       <= '0;
            byte_cnt_q  <= '0;
            chan_cnt_q  <= '0;
            frame_num_q <= '0;
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            byte_cnt_q  <= byte_cnt_d;
            chan_cnt_q  <= chan_cnt_d;
            frame_num_q <= frame_num_d;
            overflow_q  <= overflow_d;
            frame_err_q <= frame_err_d;
        end
    end

    axis_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EntryW)
    ) u_fifo (
        .clk_i   (bclk),
        .rst_i   (rst),
        .push_i  (word_done),
        .wdata_i (fifo_wdata),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Output unpacking.
    always_comb begin
        m_axis_tvalid = ~fifo_empty;
        m_axis_tdata  = fifo_rdata[EntryW-1 -: 32];
        m_axis_tuser  = fifo_rdata[CH_WIDTH:1];
        m_axis_tlast  = fifo_rdata[0];
        o_frame_num   = frame_num_q;
        o_overflow    = overflow_q;
        o_frame_err   = frame_err_q;
    end

endmodule

// File: tb/tb_i2s_word_assembler.sv
// Self-checking bench for i2s_word_assembler: directed cases plus random
// traffic against a queue-based behavioural model.
module tb_i2s_word_assembler;

    localparam int FIFO_DEPTH = 4;
    localparam int CH_WIDTH   = 4;

    logic                bclk = 1'b0;
    logic                rst = 1'b1;
    logic                s_tvalid = 1'b0;
    logic [7:0]          s_tdata = 8'h0;
    logic                s_tlast = 1'b0;
    logic                m_tvalid;
    logic                m_tready = 1'b1;
    logic [31:0]         m_tdata;
    logic [CH_WIDTH-1:0] m_tuser;
    logic                m_tlast;
    logic [5:0]          i_word_width = 6'd24;
    logic [4:0]          i_tdm_num = 5'd2;
    logic                i_enable = 1'b0;
    logic                i_clear = 1'b0;
    logic [31:0]         o_frame_num;
    logic                o_overflow;
    logic                o_frame_err;

    i2s_word_assembler #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .CH_WIDTH   (CH_WIDTH)
    ) dut (
        .bclk          (bclk),
        .rst           (rst),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tdata  (s_tdata),
        .s_axis_tlast  (s_tlast),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tuser  (m_tuser),
        .m_axis_tlast  (m_tlast),
        .i_word_width  (i_word_width),
        .i_tdm_num     (i_tdm_num),
        .i_enable      (i_enable),
        .i_clear       (i_clear),
        .o_frame_num   (o_frame_num),
        .o_overflow    (o_overflow),
        .o_frame_err   (o_frame_err)
    );

    always #5 bclk = ~bclk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  u;
        logic        l;
    } item_t;

    item_t       mq[$];
    item_t       seen[$];
    logic [7:0]  cur[$];
    int          ch = 0;
    logic [31:0] m_frames = 0;
    logic        m_ovf = 0;
    logic        m_err = 0;

    int          nbm;
    logic [7:0]  b;
    logic [7:0]  mk;
    logic [31:0] wv;
    item_t       it;
    bit          m_full, m_pop, m_push, ev_frame, ev_err, ev_ovf;

    function automatic logic [31:0] shape(input logic [31:0] lj, input int w);
`ifdef I2S_ASM_SIGN_EXT_EN
        logic signed [31:0] s;
        s = lj;
        return s >>> (32 - w);
`else
        return lj;
`endif
    endfunction

    always @(posedge bclk) begin
        if (rst) begin
            mq.delete();
            cur.delete();
            ch = 0;
            m_frames = 0;
            m_ovf = 0;
            m_err = 0;
        end else begin
            m_full = (mq.size() == FIFO_DEPTH);
            m_pop = (mq.size() != 0) && m_tready;
            m_push = 0;
            ev_frame = 0;
            ev_err = 0;
            ev_ovf = 0;
            if (!i_enable) begin
                cur.delete();
                ch = 0;
            end else if (s_tvalid) begin
                nbm = (int'(i_word_width) + 7) / 8;
                b = s_tdata;
                if (cur.size() == nbm - 1 && (i_word_width % 8) != 0) begin
                    mk = 8'hFF << (8 - int'(i_word_width % 8));
                    b = b & mk;
                end
                cur.push_back(b);
                if (cur.size() == nbm || s_tlast) begin
                    wv = 0;
                    for (int i = 0; i < cur.size(); i++) begin
                        wv = wv | (32'(cur[i]) << (24 - 8 * i));
                    end
                    it.d = shape(wv, int'(i_word_width));
                    it.u = 4'(ch);
                    it.l = s_tlast || (ch == int'(i_tdm_num) - 1);
                    if (s_tlast) begin
                        ev_frame = 1;
                        if (cur.size() != nbm || ch != int'(i_tdm_num) - 1) ev_err = 1;
                    end
                    ch = it.l ? 0 : ch + 1;
                    cur.delete();
                    m_push = 1;
                end
            end
            if (m_pop) void'(mq.pop_front());
            if (m_push) begin
                if (!m_full || m_pop) mq.push_back(it);
                else ev_ovf = 1;
            end
            if (i_clear) begin
                m_frames = 0;
                m_ovf = 0;
                m_err = 0;
            end
            if (ev_frame) m_frames = m_frames + 1;
            if (ev_err) m_err = 1;
            if (ev_ovf) m_ovf = 1;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge bclk) begin
        chk("tvalid", 64'(m_tvalid), 64'(mq.size() != 0));
        if (mq.size() != 0) begin
            chk("tdata", 64'(m_tdata), 64'(mq[0].d));
            chk("tuser", 64'(m_tuser), 64'(mq[0].u));
            chk("tlast", 64'(m_tlast), 64'(mq[0].l));
        end
        chk("frame_num", 64'(o_frame_num), 64'(m_frames));
        chk("overflow", 64'(o_overflow), 64'(m_ovf));
        chk("frame_err", 64'(o_frame_err), 64'(m_err));
        if (m_tvalid && m_tready) seen.push_back({m_tdata, m_tuser, m_tlast});
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle(input int n);
        repeat (n) @(posedge bclk);
        #2;
    endtask

    task automatic send(input logic [7:0] d, input logic l);
        s_tvalid = 1'b1;
        s_tdata = d;
        s_tlast = l;
        @(posedge bclk);
        #2;
        s_tvalid = 1'b0;
        s_tlast = 1'b0;
        s_tdata = 8'h0;
    endtask

    task automatic cfg(input int w, input int t);
        i_enable = 1'b0;
        idle(1);
        i_word_width = 6'(w);
        i_tdm_num = 5'(t);
        i_enable = 1'b1;
    endtask

    task automatic pulse_clear();
        i_clear = 1'b1;
        idle(1);
        i_clear = 1'b0;
    endtask

    task automatic wait_seen(input int n, input int budget);
        int k;
        k = 0;
        while (seen.size() < n && k < budget) begin
            idle(1);
            k++;
        end
        chk("drain_count", 64'(seen.size()), 64'(n));
    endtask

    int pos;
    int nbr;
    bit tl;

    initial begin
        rst = 1'b1;
        idle(3);
        chk("reset_tvalid", 64'(m_tvalid), 64'd0);
        chk("reset_tdata", 64'(m_tdata), 64'd0);
        chk("reset_frames", 64'(o_frame_num), 64'd0);
        chk("reset_flags", 64'({o_overflow, o_frame_err}), 64'd0);
        rst = 1'b0;

        // Two-channel 24-bit frame.
        cfg(24, 2);
        m_tready = 1'b1;
        seen.delete();
        send(8'hA1, 0); send(8'hB2, 0); send(8'hC3, 0);
        send(8'hD4, 0); send(8'hE5, 0); send(8'hF6, 1);
        wait_seen(2, 20);
`ifdef I2S_ASM_SIGN_EXT_EN
        chk("w24_ch0", 64'(seen[0]), 64'({32'hFFA1B2C3, 4'd0, 1'b0}));
        chk("w24_ch1", 64'(seen[1]), 64'({32'hFFD4E5F6, 4'd1, 1'b1}));
`else
        chk("w24_ch0", 64'(seen[0]), 64'({32'hA1B2C300, 4'd0, 1'b0}));
        chk("w24_ch1", 64'(seen[1]), 64'({32'hD4E5F600, 4'd1, 1'b1}));
`endif
        chk("w24_frames", 64'(o_frame_num), 64'd1);

        // 20-bit words with a partial final slice.
        cfg(20, 1);
        seen.delete();
        send(8'h12, 0); send(8'h34, 0); send(8'h5F, 1);
        send(8'h82, 0); send(8'h34, 0); send(8'h5F, 1);
        wait_seen(2, 20);
`ifdef I2S_ASM_SIGN_EXT_EN
        chk("w20_pos", 64'(seen[0].d), 64'h00012345);
        chk("w20_neg", 64'(seen[1].d), 64'hFFF82345);
`else
        chk("w20_pos", 64'(seen[0].d), 64'h12345000);
        chk("w20_neg", 64'(seen[1].d), 64'h82345000);
`endif
        chk("w20_tlast", 64'({seen[0].l, seen[1].l}), 64'b11);

        // Backpressure: six words into a four-entry FIFO.
        cfg(16, 8);
        pulse_clear();
        seen.delete();
        m_tready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            send(8'h10 + 8'(k), 0);
            send(8'h20 + 8'(k), 0);
        end
        idle(2);
        chk("bp_overflow", 64'(o_overflow), 64'd1);
        chk("bp_hold_user", 64'(m_tuser), 64'd0);
        m_tready = 1'b1;
        wait_seen(4, 20);
        for (int k = 0; k < 4; k++) chk("bp_order", 64'(seen[k].u), 64'(k));
        pulse_clear();
        chk("bp_clear", 64'(o_overflow), 64'd0);

        // Short word at tlast.
        cfg(16, 1);
        seen.delete();
        send(8'hAB, 1);
        wait_seen(1, 20);
`ifdef I2S_ASM_SIGN_EXT_EN
        chk("short_word", 64'(seen[0]), 64'({32'hFFFFAB00, 4'd0, 1'b1}));
`else
        chk("short_word", 64'(seen[0]), 64'({32'hAB000000, 4'd0, 1'b1}));
`endif
        chk("short_err", 64'(o_frame_err), 64'd1);
        pulse_clear();
        chk("clear_err", 64'(o_frame_err), 64'd0);
        chk("clear_frames", 64'(o_frame_num), 64'd0);

        // Push into a full FIFO while it pops.
        cfg(8, 4);
        seen.delete();
        m_tready = 1'b0;
        for (int k = 1; k <= 4; k++) send(8'(k), 0);
        m_tready = 1'b1;
        send(8'h05, 0);
        wait_seen(5, 20);
        chk("full_pp_ovf", 64'(o_overflow), 64'd0);
        chk("full_pp_user", 64'({seen[3].u, seen[3].l, seen[4].u}), 64'({4'd3, 1'b1, 4'd0}));

        // Reset in the middle of a word, then two clean frames.
        cfg(24, 2);
        send(8'h99, 0); send(8'h88, 0);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        seen.delete();
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < 6; k++) send(8'h40 + 8'(k), k == 5);
        end
        wait_seen(4, 20);
        for (int k = 0; k < 4; k++) chk("rst_chan", 64'(seen[k].u), 64'(k % 2));
        chk("rst_frames", 64'(o_frame_num), 64'd2);

        // Randomized traffic.
        for (int r = 0; r < 30; r++) begin
            cfg($urandom_range(1, 32), $urandom_range(1, 16));
            nbr = (int'(i_word_width) + 7) / 8;
            pos = 0;
            for (int c = 0; c < 200; c++) begin
                m_tready = ($urandom_range(0, 9) < 6);
                i_clear = ($urandom_range(0, 49) == 0);
                s_tvalid = ($urandom_range(0, 9) < 7);
                s_tdata = 8'($urandom);
                tl = (pos == nbr * int'(i_tdm_num) - 1) || ($urandom_range(0, 49) == 0);
                s_tlast = s_tvalid && tl;
                if (s_tvalid) pos = tl ? 0 : pos + 1;
                idle(1);
            end
            s_tvalid = 1'b0;
            s_tlast = 1'b0;
            i_clear = 1'b0;
        end

        m_tready = 1'b1;
        i_enable = 1'b0;
        idle(10);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
